// File: rtl/uart_tx_sched_if.sv
// Store-to-UART write handshake between the memory stage and the UART scheduler.
// The pipeline drives valid/data as master; the scheduler returns ready as slave.
interface uart_tx_sched_if;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;

  modport master (output wr_valid, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/uart_tx_sched.sv
// Queues CPU store-to-UART bytes and paces them out as single-cycle uart_we strobes
// spaced CHAR_GAP+1 clocks apart, so the shared serializer is never overrun.
module uart_tx_sched #(
  parameter int DEPTH    = 16,
  parameter int CHAR_GAP = 10416
) (
  input  logic                    clk,
  input  logic                    rstd,
  uart_tx_sched_if.slave          wr,
  output logic                    uart_we,
  output logic [7:0]              uart_data,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic                    busy,
  output logic                    overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(CHAR_GAP) + 1;
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] GAP_LOAD = CW'(CHAR_GAP - 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [7:0]    mem_reg [DEPTH];
  logic [7:0]    uart_data_reg;
  logic          uart_we_reg;
  logic          overflow_reg;

  logic full;
  logic empty;
  logic push;
  logic pop;

  // Wrap bit distinguishes full from empty when the index bits match.
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign empty = (wr_ptr_reg == rd_ptr_reg);

  assign wr.wr_ready = !full;
  assign push        = wr.wr_valid && !full;

  assign fifo_count = wr_ptr_reg - rd_ptr_reg;
  assign busy       = !empty || (state_reg != IDLE);
  assign uart_we    = uart_we_reg;
  assign uart_data  = uart_data_reg;
  assign overflow   = overflow_reg;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!empty) begin
          state_next = SEND;
          pop        = 1'b1;
        end
      end
      SEND: begin
        cnt_next   = GAP_LOAD;
        state_next = WAIT;
      end
      WAIT: begin
        if (cnt_reg == '0) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg - CNT_ONE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Storage carries no reset so it maps onto block/distributed RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_reg[wr_ptr_reg[AW-1:0]] <= wr.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rstd) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      uart_we_reg   <= 1'b0;
      uart_data_reg <= 8'h00;
      overflow_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      uart_we_reg <= (state_next == SEND);
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_reg    <= rd_ptr_reg + PTR_ONE;
        uart_data_reg <= mem_reg[rd_ptr_reg[AW-1:0]];
      end
      if (wr.wr_valid && full) begin
        overflow_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched (DEPTH=4, CHAR_GAP=4) with a byte scoreboard
// filled on accepted writes and drained on each uart_we strobe.
module tb_uart_tx_sched;

  logic       clk = 1'b0;
  logic       rstd;
  logic       uart_we;
  logic [7:0] uart_data;
  logic [2:0] fifo_count;
  logic       busy;
  logic       overflow;

  uart_tx_sched_if bus ();

  uart_tx_sched #(.DEPTH(4), .CHAR_GAP(4)) dut (
    .clk        (clk),
    .rstd       (rstd),
    .wr         (bus),
    .uart_we    (uart_we),
    .uart_data  (uart_data),
    .fifo_count (fifo_count),
    .busy       (busy),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         strobe_cnt = 0;
  logic [7:0] exp_q[$];
  int         strobe_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int bound);
    for (int i = 0; i < bound && busy; i++) step();
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  // Scoreboard: record accepted bytes, compare each strobe against the oldest.
  always @(negedge clk) begin
    if (!rstd && bus.wr_valid && bus.wr_ready) exp_q.push_back(bus.wr_data);
    if (uart_we) begin
      strobe_cnt++;
      strobe_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", 32'd1, 32'd0);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        chk("strobe_data", 32'(uart_data), 32'(e));
        $display("strobe cyc=%0d data=%02h expected=%02h", cyc, uart_data, e);
      end
    end
  end

  initial begin
    int base;
    int accepted;
    int max_cnt;
    logic [2:0] cnt_after2;

    // 1: reset state
    rstd = 1'b1;
    bus.wr_valid = 1'b0;
    bus.wr_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rstd = 1'b0;
    chk("rst_wr_ready", 32'(bus.wr_ready), 32'd1);
    chk("rst_uart_we", 32'(uart_we), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_uart_data", 32'(uart_data), 32'd0);

    // 2: single byte latency and busy duration
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'h41;
    step();
    bus.wr_valid = 1'b0;
    chk("lat_we_c1", 32'(uart_we), 32'd0);
    chk("lat_count_c1", 32'(fifo_count), 32'd1);
    chk("lat_busy_c1", 32'(busy), 32'd1);
    step();
    chk("lat_we_c2", 32'(uart_we), 32'd1);
    chk("lat_data_c2", 32'(uart_data), 32'h41);
    chk("lat_count_c2", 32'(fifo_count), 32'd0);
    step();
    chk("lat_we_c3", 32'(uart_we), 32'd0);
    chk("hold_data_c3", 32'(uart_data), 32'h41);
    step();
    step();
    chk("wait_busy_c5", 32'(busy), 32'd1);
    step();
    chk("idle_busy_c6", 32'(busy), 32'd0);
    chk("single_strobe", 32'(strobe_cnt), 32'd1);

    // 3: three back-to-back bytes, spacing CHAR_GAP+1
    base = strobe_cyc.size();
    bus.wr_valid = 1'b1;
    bus.wr_data = 8'h48; step();
    bus.wr_data = 8'h69; step();
    bus.wr_data = 8'h21; step();
    bus.wr_valid = 1'b0;
    for (int i = 0; i < 40 && strobe_cyc.size() < base + 3; i++) step();
    chk("burst3_strobes", 32'(strobe_cyc.size() - base), 32'd3);
    if (strobe_cyc.size() >= base + 3) begin
      chk("spacing_1_2", 32'(strobe_cyc[base+1] - strobe_cyc[base]), 32'd5);
      chk("spacing_2_3", 32'(strobe_cyc[base+2] - strobe_cyc[base+1]), 32'd5);
    end
    wait_idle(40);
    chk("burst3_drained", 32'(exp_q.size()), 32'd0);

    // 4: fill to full with gated writes, then force a write at full
    cnt_after2 = '0;
    for (int i = 0; i < 10 && fifo_count != 3'd4; i++) begin
      bus.wr_valid = bus.wr_ready;
      bus.wr_data  = 8'h50 + 8'(i);
      step();
      if (i == 1) cnt_after2 = fifo_count;
    end
    bus.wr_valid = 1'b0;
    chk("push_pop_same_cycle", 32'(cnt_after2), 32'd1);
    chk("full_count", 32'(fifo_count), 32'd4);
    chk("full_wr_ready", 32'(bus.wr_ready), 32'd0);
    chk("full_no_overflow", 32'(overflow), 32'd0);
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'hEE;
    step();
    bus.wr_valid = 1'b0;
    chk("overflow_set", 32'(overflow), 32'd1);
    wait_idle(80);
    chk("full_drained", 32'(exp_q.size()), 32'd0);
    chk("overflow_sticky", 32'(overflow), 32'd1);

    // 5: continuous refill at full across pointer wrap
    base = strobe_cnt;
    accepted = 0;
    max_cnt = 0;
    for (int i = 0; i < 200 && accepted < 10; i++) begin
      bus.wr_valid = bus.wr_ready;
      bus.wr_data  = 8'h60 + 8'(accepted);
      if (bus.wr_ready) accepted++;
      step();
      if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
    end
    bus.wr_valid = 1'b0;
    chk("wrap_accepted", 32'(accepted), 32'd10);
    chk("wrap_max_count", 32'(max_cnt), 32'd4);
    wait_idle(120);
    chk("wrap_strobes", 32'(strobe_cnt - base), 32'd10);
    chk("wrap_drained", 32'(exp_q.size()), 32'd0);

    // 6: reset during WAIT with bytes still queued
    bus.wr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.wr_data = 8'h70 + 8'(i);
      step();
    end
    bus.wr_valid = 1'b0;
    chk("pre_rst_count", 32'(fifo_count), 32'd3);
    chk("pre_rst_we", 32'(uart_we), 32'd0);
    base = strobe_cnt;
    rstd = 1'b1;
    exp_q.delete();
    step();
    rstd = 1'b0;
    chk("mid_rst_count", 32'(fifo_count), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_we", 32'(uart_we), 32'd0);
    chk("mid_rst_overflow", 32'(overflow), 32'd0);
    chk("mid_rst_wr_ready", 32'(bus.wr_ready), 32'd1);
    repeat (15) step();
    chk("no_strobe_after_rst", 32'(strobe_cnt - base), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
